// File: rtl/trap_ctrl.sv
// M/U-mode trap controller: selects interrupts/exceptions/mret at commit, owns the
// machine trap CSRs and issues a held pipeline redirect until fetch accepts it.
module trap_ctrl #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [19:0]     req_exc,
    input  logic            req_mret,
    input  logic [XLEN-1:0] req_epc,
    input  logic [XLEN-1:0] req_tval,
    input  logic [XLEN-1:0] int_pc,
    input  logic            int_allow,
    input  logic            irq_msip,
    input  logic            irq_mtip,
    input  logic            irq_meip,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      priv
);
    typedef enum logic [0:0] {IDLE, REDIRECT} state_t;

    localparam logic [1:0]  PRIV_M   = 2'b11;
    localparam logic [1:0]  PRIV_U   = 2'b00;
    localparam logic [19:0] EXC_MASK = 20'h0BBFF;
    // Highest priority first.
    localparam logic [4:0]  EXC_ORDER [14] = '{5'd3, 5'd12, 5'd1, 5'd2, 5'd0, 5'd8, 5'd9,
                                               5'd11, 5'd4, 5'd6, 5'd13, 5'd15, 5'd5, 5'd7};

    function automatic logic [4:0] exc_code(input logic [19:0] e);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 13; i >= 0; i--) begin
            if (e[EXC_ORDER[i]]) c = EXC_ORDER[i];
        end
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      priv_q, priv_d;
    logic            mstat_mie_q, mstat_mie_d;
    logic            mpie_q, mpie_d;
    logic [1:0]      mpp_q, mpp_d;
    logic [2:0]      mie_q, mie_d;      // {MEIE, MTIE, MSIE}
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] rpc_q, rpc_d;

    logic [2:0]      pend;
    logic            int_take, exc_any, exc_take, mret_take, idle;
    logic [4:0]      code;
    logic [XLEN-1:0] epc, tval, vec_off, mstatus_v, mip_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            priv_q      <= PRIV_M;
            mstat_mie_q <= 1'b0;
            mpie_q      <= 1'b0;
            mpp_q       <= PRIV_U;
            mie_q       <= '0;
            mtvec_q     <= MTVEC_RESET;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            rpc_q       <= '0;
        end else begin
            state_q     <= state_d;
            priv_q      <= priv_d;
            mstat_mie_q <= mstat_mie_d;
            mpie_q      <= mpie_d;
            mpp_q       <= mpp_d;
            mie_q       <= mie_d;
            mtvec_q     <= mtvec_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mtval_q     <= mtval_d;
            rpc_q       <= rpc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        priv_d      = priv_q;
        mstat_mie_d = mstat_mie_q;
        mpie_d      = mpie_q;
        mpp_d       = mpp_q;
        mie_d       = mie_q;
        mtvec_d     = mtvec_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mtval_d     = mtval_q;
        rpc_d       = rpc_q;

        idle      = (state_q == IDLE);
        pend      = {irq_meip, irq_mtip, irq_msip} & mie_q;
        int_take  = idle && int_allow && (|pend) && ((priv_q == PRIV_U) || mstat_mie_q);
        exc_any   = |(req_exc & EXC_MASK);
        exc_take  = idle && !int_take && req_valid && exc_any;
        mret_take = idle && !int_take && req_valid && !exc_any && req_mret;
        req_ready = idle && !int_take;

        code    = int_take ? (pend[2] ? 5'd11 : (pend[0] ? 5'd3 : 5'd7))
                           : exc_code(req_exc & EXC_MASK);
        epc     = int_take ? int_pc : req_epc;
        tval    = int_take ? '0 : req_tval;
        // Vectored mode only offsets interrupts; exceptions always land on the base.
        vec_off = (int_take && (mtvec_q[1:0] == 2'b01)) ? {{(XLEN-7){1'b0}}, code, 2'b00} : '0;

        case (state_q)
            IDLE: begin
                if (int_take || exc_take) begin
                    mepc_d      = epc & ~(XLEN'(3));
                    mcause_d    = {int_take, {(XLEN-6){1'b0}}, code};
                    mtval_d     = tval;
                    mpie_d      = mstat_mie_q;
                    mstat_mie_d = 1'b0;
                    mpp_d       = priv_q;
                    priv_d      = PRIV_M;
                    rpc_d       = {mtvec_q[XLEN-1:2], 2'b00} + vec_off;
                    state_d     = REDIRECT;
                end else if (mret_take) begin
                    priv_d      = mpp_q;
                    mstat_mie_d = mpie_q;
                    mpie_d      = 1'b1;
                    mpp_d       = PRIV_U;
                    rpc_d       = mepc_q;
                    state_d     = REDIRECT;
                end else if (csr_we) begin
                    case (csr_addr)
                        12'h300: begin
                            mstat_mie_d = csr_wdata[3];
                            mpie_d      = csr_wdata[7];
                            if (csr_wdata[12:11] == PRIV_M || csr_wdata[12:11] == PRIV_U)
                                mpp_d = csr_wdata[12:11];
                        end
                        12'h304: mie_d    = {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
                        12'h305: mtvec_d  = {csr_wdata[XLEN-1:2],
                                             csr_wdata[1] ? 2'b00 : csr_wdata[1:0]};
                        12'h341: mepc_d   = csr_wdata & ~(XLEN'(3));
                        12'h342: mcause_d = csr_wdata;
                        12'h343: mtval_d  = csr_wdata;
                        default: ;
                    endcase
                end
            end
            REDIRECT: begin
                if (redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mstatus_v        = '0;
        mstatus_v[3]     = mstat_mie_q;
        mstatus_v[7]     = mpie_q;
        mstatus_v[12:11] = mpp_q;
        mip_v            = '0;
        mip_v[3]         = irq_msip;
        mip_v[7]         = irq_mtip;
        mip_v[11]        = irq_meip;
        case (csr_addr)
            12'h300: csr_rdata = mstatus_v;
            12'h304: csr_rdata = {{(XLEN-12){1'b0}}, mie_q[2], 3'b000, mie_q[1], 3'b000,
                                  mie_q[0], 3'b000};
            12'h305: csr_rdata = mtvec_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            12'h344: csr_rdata = mip_v;
            default: csr_rdata = '0;
        endcase
    end

    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = rpc_q;
    assign priv           = priv_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: CSR WARL table plus hand-written trap/mret/redirect sequences.
module tb_trap_ctrl;
    logic        clk, rst;
    logic        req_valid, req_ready, req_mret;
    logic [19:0] req_exc;
    logic [31:0] req_epc, req_tval, int_pc;
    logic        int_allow, irq_msip, irq_mtip, irq_meip;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
    logic [1:0]  priv;

    trap_ctrl #(.XLEN(32), .MTVEC_RESET(32'h100)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_exc(req_exc),
        .req_mret(req_mret), .req_epc(req_epc), .req_tval(req_tval),
        .int_pc(int_pc), .int_allow(int_allow),
        .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .priv(priv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(name, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic handshake(input string name);
        redirect_ready = 1'b1;
        tick();
        chk(name, redirect_valid, 1'b0);
        redirect_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_mret = 0; req_exc = '0; req_epc = '0; req_tval = '0;
        int_pc = '0; int_allow = 0; irq_msip = 0; irq_mtip = 0; irq_meip = 0;
        csr_we = 0; csr_addr = '0; csr_wdata = '0; redirect_ready = 0;

        vecs[0]  = '{12'h305, 32'h0000_0203, 32'h0000_0200};
        vecs[1]  = '{12'h305, 32'h0000_0101, 32'h0000_0101};
        vecs[2]  = '{12'h305, 32'h0000_0102, 32'h0000_0100};
        vecs[3]  = '{12'h300, 32'h0000_1888, 32'h0000_1888};
        vecs[4]  = '{12'h300, 32'h0000_0808, 32'h0000_1808};
        vecs[5]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888};
        vecs[6]  = '{12'h300, 32'h0000_1000, 32'h0000_1800};
        vecs[7]  = '{12'h304, 32'hFFFF_FFFF, 32'h0000_0888};
        vecs[8]  = '{12'h304, 32'h0000_0008, 32'h0000_0008};
        vecs[9]  = '{12'h341, 32'h0000_1237, 32'h0000_1234};
        vecs[10] = '{12'h342, 32'h8000_0003, 32'h8000_0003};
        vecs[11] = '{12'h343, 32'h0000_CAFE, 32'h0000_CAFE};
        vecs[12] = '{12'h344, 32'h0000_FFFF, 32'h0000_0000};
        vecs[13] = '{12'h7FF, 32'h0000_1234, 32'h0000_0000};

        // Reset state
        tick(); tick();
        chk("rst_priv", priv, 2'b11);
        chk("rst_rv", redirect_valid, 1'b0);
        chk("rst_rpc", redirect_pc, 32'h0);
        chk_csr("rst_mtvec", 12'h305, 32'h100);
        chk_csr("rst_mstatus", 12'h300, 32'h0);
        rst = 1'b0;
        tick();

        // Exception: II and IPF set, IPF wins
        req_valid = 1; req_exc = 20'h01004; req_epc = 32'h80; req_tval = 32'hDEAD;
        #1;
        chk("exc_ready", req_ready, 1'b1);
        tick();
        req_valid = 0; req_exc = '0;
        chk("exc_rv", redirect_valid, 1'b1);
        chk("exc_rpc", redirect_pc, 32'h100);
        chk_csr("exc_mcause", 12'h342, 32'd12);
        chk_csr("exc_mepc", 12'h341, 32'h80);
        chk_csr("exc_mtval", 12'h343, 32'hDEAD);
        chk_csr("exc_mstatus", 12'h300, 32'h1800);
        handshake("exc_done");

        // Vectored interrupt, MEI beats MTI and a simultaneous request
        wr(12'h305, 32'h201);
        wr(12'h304, 32'h888);
        wr(12'h300, 32'h8);
        irq_mtip = 1; irq_meip = 1; int_allow = 1; int_pc = 32'h44;
        req_valid = 1; req_exc = 20'h00004; req_epc = 32'h99; req_tval = 32'h77;
        #1;
        chk("int_ready", req_ready, 1'b0);
        tick();
        req_valid = 0; req_exc = '0; int_allow = 0; irq_mtip = 0; irq_meip = 0;
        chk("int_rv", redirect_valid, 1'b1);
        chk("int_rpc", redirect_pc, 32'h22C);
        chk_csr("int_mcause", 12'h342, 32'h8000_000B);
        chk_csr("int_mepc", 12'h341, 32'h44);
        chk_csr("int_mtval", 12'h343, 32'h0);
        chk_csr("int_mstatus", 12'h300, 32'h1880);
        handshake("int_done");

        // mret into U, then an ecall from U
        wr(12'h300, 32'h80);
        wr(12'h341, 32'h1000);
        req_valid = 1; req_mret = 1;
        tick();
        req_valid = 0; req_mret = 0;
        chk("mret_rpc", redirect_pc, 32'h1000);
        chk("mret_priv", priv, 2'b00);
        chk_csr("mret_mstatus", 12'h300, 32'h88);
        handshake("mret_done");
        req_valid = 1; req_exc = 20'h00100; req_epc = 32'h2002; req_tval = 32'h0;
        tick();
        req_valid = 0; req_exc = '0;
        chk("ecu_priv", priv, 2'b11);
        chk("ecu_rpc", redirect_pc, 32'h200);
        chk_csr("ecu_mcause", 12'h342, 32'd8);
        chk_csr("ecu_mepc", 12'h341, 32'h2000);
        chk_csr("ecu_mstatus", 12'h300, 32'h80);
        handshake("ecu_done");

        // Redirect held by fetch; CSR write is dropped; reset abandons it
        req_valid = 1; req_exc = 20'h00009; req_epc = 32'h300; req_tval = 32'h5;
        tick();
        req_valid = 0; req_exc = '0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rv", redirect_valid, 1'b1);
            chk("hold_rpc", redirect_pc, 32'h200);
            chk("hold_ready", req_ready, 1'b0);
            if (i == 2) csr_we = 1;
            csr_addr = 12'h304; csr_wdata = 32'h0;
            tick();
            csr_we = 0;
        end
        chk_csr("hold_mcause", 12'h342, 32'd3);
        chk_csr("hold_mie", 12'h304, 32'h888);
        rst = 1'b1;
        #1;
        chk("hold_rst_rv", redirect_valid, 1'b0);
        chk("hold_rst_priv", priv, 2'b11);
        tick();
        rst = 1'b0;
        tick();

        // CSR write/read table
        for (int i = 0; i < 14; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            chk_csr($sformatf("csr_vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Live mip, then MSI beats MTI in direct mode
        irq_msip = 1; irq_mtip = 1;
        chk_csr("mip_live", 12'h344, 32'h88);
        wr(12'h304, 32'h888);
        wr(12'h300, 32'h1808);
        int_allow = 1; int_pc = 32'h51;
        tick();
        int_allow = 0; irq_msip = 0; irq_mtip = 0;
        chk("msi_rv", redirect_valid, 1'b1);
        chk("msi_rpc", redirect_pc, 32'h100);
        chk_csr("msi_mcause", 12'h342, 32'h8000_0003);
        chk_csr("msi_mepc", 12'h341, 32'h50);
        handshake("msi_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
